// File: rtl/sha256_multiblock_core.sv
// SHA-256 compression over 1..MAX_BLOCKS pre-padded blocks, chaining H between blocks.
// Per block: 64/ROUNDS_PER_CYCLE compute cycles + 1 add cycle; blocks taken on a valid/ready handshake.
module sha256_multiblock_core #(
    parameter int MAX_BLOCKS       = 16,
    parameter int ROUNDS_PER_CYCLE = 1,
    localparam int NBW             = $clog2(MAX_BLOCKS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NBW-1:0]   num_blocks,
    input  logic [7:0][31:0] init_hash,
    input  logic [15:0][31:0] blk_data,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic [7:0][31:0] hash_out,
    output logic             done,
    output logic             err,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, WAIT_BLK, COMPUTE, ADD, FINISH} state_t;

    localparam logic [NBW-1:0] MAX_NB     = NBW'(MAX_BLOCKS);
    localparam logic [5:0]     LAST_GROUP = 6'(64 - ROUNDS_PER_CYCLE);
    localparam logic [5:0]     RND_STEP   = 6'(ROUNDS_PER_CYCLE);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t            state;
    logic [7:0][31:0]  h_reg;
    logic [7:0][31:0]  wv;       // working vars, wv[0] = a ... wv[7] = h
    logic [15:0][31:0] w;        // sliding schedule window, w[0] = W[t]
    logic [NBW-1:0]    nblk;
    logic [NBW-1:0]    blk_cnt;
    logic [5:0]        rnd_idx;
    logic [7:0][31:0]  wv_nxt;
    logic [15:0][31:0] w_nxt;
    logic [7:0][31:0]  h_sum;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sched_next(input logic [15:0][31:0] x);
        logic [31:0] s0;
        logic [31:0] s1;
        s0 = rotr(x[1], 7) ^ rotr(x[1], 18) ^ (x[1] >> 3);
        s1 = rotr(x[14], 17) ^ rotr(x[14], 19) ^ (x[14] >> 10);
        return s1 + x[9] + s0 + x[0];
    endfunction

    function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] v,
                                                   input logic [31:0] wt,
                                                   input logic [31:0] kt);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt + wt;
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        return {v[6], v[5], v[4], v[3] + t1, v[2], v[1], v[0], t1 + t2};
    endfunction

    // ROUNDS_PER_CYCLE rounds chained combinationally; the window shifts once per round.
    always_comb begin
        logic [7:0][31:0]  s;
        logic [15:0][31:0] x;
        s = wv;
        x = w;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            s = sha_round(s, x[0], K[rnd_idx + 6'(j)]);
            x = {sched_next(x), x[15:1]};
        end
        wv_nxt = s;
        w_nxt  = x;
    end

    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) h_sum[i] = h_reg[i] + wv[i];
    end

    assign blk_ready = (state == WAIT_BLK);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            h_reg    <= '0;
            wv       <= '0;
            w        <= '0;
            nblk     <= '0;
            blk_cnt  <= '0;
            rnd_idx  <= '0;
            hash_out <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_blocks != '0 && num_blocks <= MAX_NB) begin
                            h_reg   <= init_hash;
                            nblk    <= num_blocks;
                            blk_cnt <= '0;
                            state   <= WAIT_BLK;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WAIT_BLK: begin
                    if (blk_valid) begin
                        w       <= blk_data;
                        wv      <= h_reg;
                        rnd_idx <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    wv      <= wv_nxt;
                    w       <= w_nxt;
                    rnd_idx <= rnd_idx + RND_STEP;
                    if (rnd_idx == LAST_GROUP) state <= ADD;
                end
                ADD: begin
                    h_reg   <= h_sum;
                    blk_cnt <= blk_cnt + NBW'(1);
                    // Digest is registered on the way into FINISH so done is high during FINISH.
                    if (blk_cnt + NBW'(1) == nblk) begin
                        hash_out <= h_sum;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        state <= WAIT_BLK;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Bench for sha256_multiblock_core: three instances (1, 2, 4 rounds/cycle) checked against a textbook SHA-256 model.
module tb_sha256_multiblock_core;

    typedef logic [7:0][31:0]  hash_t;
    typedef logic [15:0][31:0] blk_t;

    localparam int NU   = 3;
    localparam int MAXB = 16;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_s [NU];
    logic [4:0] nb_s    [NU];
    hash_t      ih_s    [NU];
    blk_t       bd_s    [NU];
    logic       bv_s    [NU];
    logic       rdy_s   [NU];
    hash_t      ho_s    [NU];
    logic       done_s  [NU];
    logic       err_s   [NU];
    logic       busy_s  [NU];

    genvar g;
    for (g = 0; g < NU; g++) begin : g_dut
        sha256_multiblock_core #(.MAX_BLOCKS(MAXB), .ROUNDS_PER_CYCLE(1 << g)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start_s[g]),
            .num_blocks (nb_s[g]),
            .init_hash  (ih_s[g]),
            .blk_data   (bd_s[g]),
            .blk_valid  (bv_s[g]),
            .blk_ready  (rdy_s[g]),
            .hash_out   (ho_s[g]),
            .done       (done_s[g]),
            .err        (err_s[g]),
            .busy       (busy_s[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hash_t compress(input hash_t h, input blk_t b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, gg, hh, t1, t2;
        hash_t r;
        for (int t = 0; t < 16; t++) w[t] = b[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        a = h[0]; bb = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; gg = h[6]; hh = h[7];
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & gg)) + KT[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = gg; gg = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
        end
        r[0] = h[0] + a;  r[1] = h[1] + bb; r[2] = h[2] + c;  r[3] = h[3] + d;
        r[4] = h[4] + e;  r[5] = h[5] + f;  r[6] = h[6] + gg; r[7] = h[7] + hh;
        return r;
    endfunction

    // Literals are written big-endian (H0 / W0 first); these put word 0 at index 0.
    function automatic hash_t mkh(input logic [255:0] v);
        hash_t h;
        for (int i = 0; i < 8; i++) h[i] = v[255 - 32*i -: 32];
        return h;
    endfunction

    function automatic blk_t mkb(input logic [511:0] v);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = v[511 - 32*i -: 32];
        return b;
    endfunction

    hash_t iv_h, dig_abc, dig_2blk;
    blk_t  abc_blk, b0_blk, b1_blk;
    blk_t  msg [2];

    // Expectations written by the driver, consumed by the compare process.
    int    exp_done_cyc  [NU];
    int    exp_err_cyc   [NU];
    int    exp_start_cyc [NU];
    int    last_hs       [NU];
    int    rdy_lo        [NU];
    int    rdy_hi        [NU];
    hash_t exp_digest    [NU];
    int    timeouts;
    bit    all_done;

    // ---------------- compare process ----------------
    hash_t exp_hold [NU];
    int    checks = 0;
    int    errors = 0;
    bit    cmp_d;
    int    cmp_per;

    task automatic chkb(input string nm, input int u, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s unit=%0d cyc=%0d got=%b want=%b", nm, u, cyc, act, exp);
        end
    endtask

    task automatic chkh(input string nm, input int u, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s unit=%0d cyc=%0d got=%h want=%h", nm, u, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc == 2) begin
            chkh("model_abc", 0, compress(iv_h, abc_blk), dig_abc);
            chkh("model_2blk", 0, compress(compress(iv_h, b0_blk), b1_blk), dig_2blk);
        end
        for (int u = 0; u < NU; u++) begin
            cmp_per = 64 >> u;
            if (!reset_n) begin
                exp_hold[u] = '0;
                chkb("rst_done", u, done_s[u], 1'b0);
                chkb("rst_err", u, err_s[u], 1'b0);
                chkb("rst_busy", u, busy_s[u], 1'b0);
                chkb("rst_ready", u, rdy_s[u], 1'b0);
                chkh("rst_hash", u, ho_s[u], '0);
            end else begin
                cmp_d = (cyc == exp_done_cyc[u]);
                if (cmp_d) exp_hold[u] = exp_digest[u];
                chkb("done", u, done_s[u], cmp_d);
                chkh("hash_out", u, ho_s[u], exp_hold[u]);
                chkb("err", u, err_s[u], cyc == exp_err_cyc[u]);
                if (cyc == exp_err_cyc[u]) chkb("busy_on_err", u, busy_s[u], 1'b0);
                if (cyc == exp_start_cyc[u]) begin
                    chkb("busy_after_start", u, busy_s[u], 1'b1);
                    chkb("ready_after_start", u, rdy_s[u], 1'b1);
                end
                if (cyc >= last_hs[u] && cyc <= last_hs[u] + cmp_per)
                    chkb("ready_in_compute", u, rdy_s[u], 1'b0);
                if (cyc >= rdy_lo[u] && cyc <= rdy_hi[u])
                    chkb("ready_in_stall", u, rdy_s[u], 1'b1);
                if (cmp_d) chkb("busy_at_done", u, busy_s[u], 1'b1);
                if (exp_done_cyc[u] > 0 && cyc == exp_done_cyc[u] + 1)
                    chkb("busy_after_done", u, busy_s[u], 1'b0);
            end
        end
        if (all_done) begin
            chkh("handshake_timeouts", 0, 256'(timeouts), '0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (cyc > 30000) begin
            errors++;
            $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ---------------- driver ----------------
    // Handshake on edge hs: done must be seen after edge hs + 64/R + 1, i.e. in the
    // (64/R + 2)-th cycle counted from the handshake (66 / 34 / 18 cycles).
    task automatic run_msg(input int u, input hash_t iv, input int nb, input int stall, input bit poke);
        int    per;
        int    n;
        hash_t h;
        per = 64 >> u;
        h = iv;
        for (int b = 0; b < nb; b++) h = compress(h, msg[b]);
        exp_digest[u] = h;
        @(negedge clk);
        start_s[u] = 1'b1; nb_s[u] = 5'(nb); ih_s[u] = iv;
        @(posedge clk); #1 exp_start_cyc[u] = cyc;
        @(negedge clk);
        start_s[u] = 1'b0; ih_s[u] = ~iv;
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (!rdy_s[u] && n < 300) begin @(negedge clk); n++; end
            if (n >= 300) timeouts++;
            if (b == 1 && stall > 0) begin
                rdy_lo[u] = cyc; rdy_hi[u] = cyc + stall;
                repeat (stall) @(negedge clk);
            end
            bd_s[u] = msg[b]; bv_s[u] = 1'b1;
            @(posedge clk); #1 last_hs[u] = cyc;
            if (b == nb - 1) exp_done_cyc[u] = cyc + per + 1;
            @(negedge clk);
            bv_s[u] = poke; bd_s[u] = ~msg[b];
            if (poke && b == 0) begin
                repeat (4) @(negedge clk);
                start_s[u] = 1'b1; nb_s[u] = 5'd1; ih_s[u] = ~iv;
                @(negedge clk);
                start_s[u] = 1'b0;
            end
            bv_s[u] = 1'b0;
        end
        while (cyc < exp_done_cyc[u] + 2) @(negedge clk);
    endtask

    task automatic bad_start(input int u, input int nb);
        @(negedge clk);
        start_s[u] = 1'b1; nb_s[u] = 5'(nb); ih_s[u] = ~iv_h;
        @(posedge clk); #1 exp_err_cyc[u] = cyc;
        @(negedge clk);
        start_s[u] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        iv_h     = mkh(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
        dig_abc  = mkh(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        dig_2blk = mkh(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
        abc_blk  = mkb(512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018);
        b0_blk   = mkb(512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000);
        b1_blk   = mkb(512'h1c0);
        timeouts = 0;
        all_done = 1'b0;
        for (int u = 0; u < NU; u++) begin
            start_s[u] = 1'b0; nb_s[u] = '0; ih_s[u] = '0; bd_s[u] = '0; bv_s[u] = 1'b0;
            exp_done_cyc[u] = -1; exp_err_cyc[u] = -1; exp_start_cyc[u] = -1;
            last_hs[u] = -1000; rdy_lo[u] = -1; rdy_hi[u] = -2; exp_digest[u] = '0;
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int u = 0; u < NU; u++) begin
            msg[0] = abc_blk;
            run_msg(u, iv_h, 1, 0, 1'b0);
            msg[0] = b0_blk; msg[1] = b1_blk;
            run_msg(u, iv_h, 2, 10, 1'b0);
            bad_start(u, 0);
            bad_start(u, MAXB + 1);
            run_msg(u, iv_h, 2, 0, 1'b1);
        end

        // Abort block 1 of 2 on the single-round instance, then rerun "abc".
        @(negedge clk);
        start_s[0] = 1'b1; nb_s[0] = 5'd2; ih_s[0] = iv_h;
        @(posedge clk); #1 exp_start_cyc[0] = cyc;
        @(negedge clk);
        start_s[0] = 1'b0; bd_s[0] = b0_blk; bv_s[0] = 1'b1;
        @(posedge clk); #1 last_hs[0] = cyc;
        @(negedge clk);
        bv_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        exp_done_cyc[0] = -1; last_hs[0] = -1000;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        msg[0] = abc_blk;
        run_msg(0, iv_h, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        all_done = 1'b1;
    end

endmodule

// File: doc/sha256_multiblock_core.md
# sha256_multiblock_core

Parametrised SHA-256 compression engine that hashes a message of 1..MAX_BLOCKS pre-padded 512-bit blocks, chaining the intermediate hash between blocks. Message blocks arrive one at a time over a valid/ready handshake, and the rounds-per-cycle count is configurable. It is the multi-block successor to the single-block core and sits between the message buffer or padder and the hash result consumer. Padding is the upstream block's job.

## Interface
Parameters:
- MAX_BLOCKS, 16, maximum number of blocks per message (1..255)
- ROUNDS_PER_CYCLE, 1, rounds computed per clock; legal values 1, 2, 4
- NBW, $clog2(MAX_BLOCKS+1), width of num_blocks (derived, not overridable)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin a message; sampled only in IDLE
- num_blocks  input  NBW  block count of the message; sampled with start
- init_hash  input  32x8  seed H0..H7; sampled with start
- blk_data  input  32x16  one 512-bit block, word 0 = W0 (big-endian message order)
- blk_valid  input  1  blk_data is valid
- blk_ready  output  1  core accepts a block this cycle
- hash_out  output  32x8  final digest H0..H7; holds until the next done
- done  output  1  one-cycle pulse when hash_out is updated
- err  output  1  one-cycle pulse when start is rejected
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT_BLK, COMPUTE, ADD, FINISH.
- **IDLE.** On start:
  - If 1 <= num_blocks <= MAX_BLOCKS: latch H <- init_hash, latch num_blocks, blk_cnt <- 0, go to WAIT_BLK.
  - If num_blocks == 0 or num_blocks > MAX_BLOCKS: pulse err the next cycle and stay in IDLE. H and hash_out are unchanged.
- **WAIT_BLK.** blk_ready = 1 (combinational from state only, never from blk_valid).
  - On blk_valid & blk_ready: W[0..15] <- blk_data, {a..h} <- H, round <- 0, go to COMPUTE.
- **COMPUTE.** Each cycle runs ROUNDS_PER_CYCLE standard SHA-256 rounds, chained combinationally.
  - Uses the K[round+j] constants and a 16-entry shifting schedule: W[15] <- s1(W[14]) + W[9] + s0(W[1]) + W[0], applied once per round.
  - round advances by ROUNDS_PER_CYCLE. When the last group (rounds 64-ROUNDS_PER_CYCLE..63) completes, go to ADD.
- **ADD.** H[i] <- H[i] + {a..h}[i], all mod 2^32; blk_cnt <- blk_cnt + 1.
  - If blk_cnt+1 == num_blocks, go to FINISH; otherwise go to WAIT_BLK.
- **FINISH.** hash_out <- H, done <- 1 (registered, one cycle), go to IDLE.
- All additions are 32-bit, with carries discarded.
- start asserted while busy is ignored: no err, and no effect on the current hash.
- blk_valid outside WAIT_BLK is ignored; blk_data is not sampled.

## Timing
- **Reset values:** state IDLE, blk_ready 0, done 0, err 0, busy 0, hash_out all 0, H/W/a..h 0.
- **Reset mid-operation:** aborts immediately to the reset values. No done is produced.
- start accepted at edge T: busy and blk_ready are high from cycle T+1.
- Block handshake at edge B:
  - COMPUTE occupies 64/ROUNDS_PER_CYCLE cycles.
  - ADD takes 1 cycle.
  - Per-block cost = 64/ROUNDS_PER_CYCLE + 2 cycles from handshake to blk_ready re-asserting (66 for ROUNDS_PER_CYCLE=1).
- Final block handshake at edge B: done is high in cycle B + 64/ROUNDS_PER_CYCLE + 2, and hash_out is valid in the same cycle. busy drops one cycle later.
- start in the same cycle the FINISH -> IDLE transition occurs is ignored. The earliest new start is accepted in the cycle after done.
- Upstream stalls (blk_valid low in WAIT_BLK) add cycles without limit. No state changes while stalled.
- The combinational path for ROUNDS_PER_CYCLE=4 is the critical path; the multi-cycle path is not relaxed.

## Test plan
- **Single block, "abc":**
  - Stimulus: padded block 61626380 0..0 00000018, standard IV (6a09e667 ... 5be0cd19), num_blocks=1.
  - Response: hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with done exactly 66 cycles after the block handshake (ROUNDS_PER_CYCLE=1).
- **Two blocks, 56-byte "abcdbcde...nopq":**
  - Stimulus: num_blocks=2, with 10 stall cycles inserted before the second block.
  - Response: hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and blk_ready is low during COMPUTE/ADD.
- **ROUNDS_PER_CYCLE = 2 and 4:** repeat both vectors; digests are identical, with done at handshake+34 and handshake+18 cycles respectively.
- **Illegal block counts:**
  - num_blocks=0 -> err pulses one cycle, busy stays 0, hash_out unchanged.
  - num_blocks=MAX_BLOCKS+1 -> same response.
- **start while busy:** start pulsed mid-COMPUTE with a different init_hash -> digest still matches the original message, and no err.
- **Reset mid-operation:** reset_n low during COMPUTE of block 1 of 2 -> all outputs at reset values. A new "abc" run afterwards produces the correct digest.
